// File: rtl/seq_signed_div.sv
// Iterative 16-bit signed divider: restoring radix-2 on magnitudes, one quotient bit per clock.
// Start/done handshake with fixed 17-cycle latency (1 cycle for divide-by-zero).
module seq_signed_div (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        start_i,
    input  logic [15:0] dividend_i,
    input  logic [15:0] divisor_i,
    output logic [15:0] quotient_o,
    output logic [15:0] remainder_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_by_zero_o,
    output logic        overflow_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q;
    logic [15:0] d_q;
    logic [15:0] dmag_q;
    logic [16:0] r_q;
    logic [3:0]  cnt_q;
    logic        sign_q_q, sign_r_q, ovf_case_q;
    logic [15:0] quotient_q, remainder_q;
    logic        busy_q, done_q, dbz_q, ovf_q;

    logic [15:0] dvd_mag_d, dvs_mag_d;
    logic [16:0] r_shift_d, r_sub_d;
    logic        ge_d;

    assign dvd_mag_d = dividend_i[15] ? (~dividend_i + 16'd1) : dividend_i;
    assign dvs_mag_d = divisor_i[15]  ? (~divisor_i  + 16'd1) : divisor_i;

    // Partial remainder stays below |divisor| <= 32768, so the shift never loses a set bit.
    assign r_shift_d = (r_q << 1) | {16'd0, d_q[15]};
    assign ge_d      = r_shift_d >= {1'b0, dmag_q};
    assign r_sub_d   = r_shift_d - {1'b0, dmag_q};

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_q     <= IDLE;
            d_q         <= '0;
            dmag_q      <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            ovf_case_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (divisor_i == 16'd0) begin
                            quotient_q  <= 16'hFFFF;
                            remainder_q <= dividend_i;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            d_q        <= dvd_mag_d;
                            dmag_q     <= dvs_mag_d;
                            r_q        <= '0;
                            cnt_q      <= '0;
                            sign_q_q   <= dividend_i[15] ^ divisor_i[15];
                            sign_r_q   <= dividend_i[15];
                            ovf_case_q <= (dividend_i == 16'h8000) && (divisor_i == 16'hFFFF);
                            busy_q     <= 1'b1;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= ge_d ? r_sub_d : r_shift_d;
                    d_q   <= {d_q[14:0], ge_d};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15)
                        state_q <= FIX;
                end
                FIX: begin
                    // 0x8000 / -1 wraps naturally: magnitude 32768 with positive sign reads as 0x8000.
                    quotient_q  <= sign_q_q ? (~d_q + 16'd1) : d_q;
                    remainder_q <= sign_r_q ? (~r_q[15:0] + 16'd1) : r_q[15:0];
                    ovf_q       <= ovf_case_q;
                    dbz_q       <= 1'b0;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_seq_signed_div.sv
// Bench for seq_signed_div: vector table + random vectors through a scoreboard,
// plus hand sequences for ignored start, mid-run reset and back-to-back operation.
module tb_seq_signed_div;
    logic        clk = 1'b0;
    logic        n_rst, start;
    logic [15:0] dividend, divisor;
    logic [15:0] quotient, remainder;
    logic        busy, done, dbz, ovf;

    always #5 clk = ~clk;

    seq_signed_div dut (
        .clk_i(clk), .n_rst_i(n_rst), .start_i(start),
        .dividend_i(dividend), .divisor_i(divisor),
        .quotient_o(quotient), .remainder_o(remainder),
        .busy_o(busy), .done_o(done),
        .div_by_zero_o(dbz), .overflow_o(ovf)
    );

    typedef struct {
        logic [15:0] dvd, dvs, q, r;
        logic        dbz, ovf;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[15];
    int   n_cmp = 0, n_bad = 0, n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference built on the simulator's own signed division.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        int   sa, sb;
        v.dvd = a; v.dvs = b; v.dbz = 1'b0; v.ovf = 1'b0;
        sa = int'($signed(a)); sb = int'($signed(b));
        if (b == 16'd0) begin
            v.q = 16'hFFFF; v.r = a; v.dbz = 1'b1;
        end else begin
            v.q = 16'(sa / sb); v.r = 16'(sa % sb);
            v.ovf = (a == 16'h8000) && (b == 16'hFFFF);
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, b, q, r, input logic z, o);
        vec_t v;
        v.dvd = a; v.dvs = b; v.q = q; v.r = r; v.dbz = z; v.ovf = o;
        return v;
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (done) begin
            n_done++;
            chk("done_has_expect", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", dbz, e.dbz);
                chk("overflow", ovf, e.ovf);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input vec_t v, input bit push);
        start = 1'b1; dividend = v.dvd; divisor = v.dvs;
        if (push) sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    endtask

    // lat counts rising edges since accept; bounded so a dead DUT cannot hang the run.
    task automatic wait_done(input int lat0, input int exp_lat, input string nm);
        int lat;
        lat = lat0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        issue(v, 1'b1);
        chk({nm, "_busy"}, busy, v.dvs != 16'd0);
        wait_done(0, (v.dvs == 16'd0) ? 0 : 17, nm);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int d0;
        tbl[0]  = mk(16'd100,  16'd7,    16'h000E, 16'h0002, 0, 0);
        tbl[1]  = mk(16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 0, 0);
        tbl[2]  = mk(16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 0, 0);
        tbl[3]  = mk(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1);
        tbl[4]  = mk(16'h8000, 16'h0002, 16'hC000, 16'h0000, 0, 0);
        tbl[5]  = mk(16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1, 0);
        tbl[6]  = mk(16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 0, 0);
        tbl[7]  = mk(16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 0, 0);
        tbl[8]  = mk(16'h0005, 16'h0007, 16'h0000, 16'h0005, 0, 0);
        tbl[9]  = mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 0);
        tbl[10] = mk(16'h8000, 16'h0001, 16'h8000, 16'h0000, 0, 0);
        tbl[11] = mk(16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 0);
        tbl[12] = mk(16'h0001, 16'h8000, 16'h0000, 16'h0001, 0, 0);
        tbl[13] = mk(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 0, 0);
        tbl[14] = mk(16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 0, 0);

        n_rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_ovf", ovf, 0);
        n_rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 12; i++)
            run_vec(model(16'($urandom), (i % 6 == 5) ? 16'd0 : 16'($urandom_range(0, 65535) >> (i % 4) * 4)),
                    $sformatf("rnd%0d", i));

        // start during CALC must be ignored
        d0 = n_done;
        issue(mk(16'd1000, 16'd3, 16'd333, 16'd1, 0, 0), 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd5; divisor = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 17, "ignored_start");
        repeat (25) @(negedge clk);
        chk("ignored_start_done_count", n_done - d0, 1);

        // reset mid-operation aborts with no done
        d0 = n_done;
        issue(mk(16'd1000, 16'd3, 16'd333, 16'd1, 0, 0), 1'b0);
        repeat (7) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);

        // back-to-back: new start on the done cycle
        issue(mk(16'd50, 16'd5, 16'd10, 16'd0, 0, 0), 1'b1);
        wait_done(0, 17, "b2b_first");
        issue(mk(16'd9, 16'd4, 16'd2, 16'd1, 0, 0), 1'b1);
        chk("b2b_busy", busy, 1);
        chk("b2b_done_drop", done, 0);
        wait_done(0, 17, "b2b_second");
        @(negedge clk);

        // recovery after everything
        run_vec(tbl[0], "final");
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
